io_mmio_bridge_wait: RTL and testbench

Parametrised successor of the MicroBlaze MCS I/O-to-MMIO bridge. It sits between the MCS I/O bus and `mmio_top` and adds two things:
- per-transaction wait handling, in either fixed-latency or slave-acknowledge mode;
- bus-error reporting for out-of-window addresses and slave timeouts.

Every MCS access gets exactly one `o_io_ready` pulse. A hung or unmapped slave never stalls the processor.

---
 rtl/mmio_bridge_pkg.sv | 21 ++
 rtl/mmio_wait_timer.sv | 35 +++
 rtl/io_mmio_bridge_wait.sv | 186 ++++++++++++++++++
 tb/tb_io_mmio_bridge_wait.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared types and constants for the MCS I/O to MMIO bridge with wait handling.
package mmio_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE,
        ERROR
    } bridge_state_t;

    localparam logic [1:0]  IO_WINDOW_TAG    = 2'b11;
    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;
    localparam int          TIMER_W          = 16;
    localparam int          ERR_COUNT_W      = 8;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == {ERR_COUNT_W{1'b1}}) ? v : v + {{(ERR_COUNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mmio_wait_timer.sv
// Loadable 16-bit down-counter; o_expired is high while the count sits at zero.
module mmio_wait_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == '0);

endmodule

// File: rtl/io_mmio_bridge_wait.sv
// MCS I/O bus to MMIO bridge: one ready pulse per access, fixed-latency or ack-driven
// completion, and error reporting for out-of-window addresses and slave timeouts.
module io_mmio_bridge_wait
    import mmio_bridge_pkg::*;
#(
    parameter int          ADDR_W       = 21,
    parameter int          ACK_MODE     = 0,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] ERR_WORD     = ERR_WORD_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_io_addr_strobe,
    input  logic              i_io_read_strobe,
    input  logic              i_io_write_strobe,
    input  logic [3:0]        i_io_byte_enable,
    input  logic [31:0]       i_io_address,
    input  logic [31:0]       i_io_write_data,
    output logic [31:0]       o_io_read_data,
    output logic              o_io_ready,
    output logic              o_mmio_cs,
    output logic              o_mmio_write,
    output logic              o_mmio_read,
    output logic [ADDR_W-1:0] o_mmio_addr,
    output logic [3:0]        o_mmio_byte_en,
    output logic [31:0]       o_mmio_write_data,
    input  logic [31:0]       i_mmio_read_data,
    input  logic              i_mmio_ack,
    input  logic              i_err_clear,
    output logic              o_err_flag,
    output logic [7:0]        o_err_count
);

    localparam bit ACK = (ACK_MODE != 0);
    // The timer reads zero in the final WAIT cycle, so both modes load "cycles - 1";
    // in ack mode this makes the WAIT window exactly TIMEOUT cycles long.
    localparam logic [TIMER_W-1:0] LOAD_VAL = ACK ? TIMER_W'(TIMEOUT - 1)
                                                  : TIMER_W'(READ_LATENCY - 1);

    bridge_state_t     state_q;
    logic              is_read_q;
    logic              io_ready_q;
    logic [31:0]       io_rdata_q;
    logic              mmio_cs_q;
    logic              mmio_read_q;
    logic              mmio_write_q;
    logic [ADDR_W-1:0] mmio_addr_q;
    logic [3:0]        mmio_be_q;
    logic [31:0]       mmio_wdata_q;
    logic              err_flag_q;
    logic              err_flag_d;
    logic [7:0]        err_count_q;
    logic [7:0]        err_count_d;

    logic start;
    logic in_window;
    logic ack_hit;
    logic timer_load;
    logic timer_dec;
    logic timer_expired;
    logic err_event;
    logic unused_addr;

    assign start      = i_io_addr_strobe && (i_io_read_strobe ^ i_io_write_strobe);
    assign in_window  = (i_io_address[31:30] == IO_WINDOW_TAG);
    assign ack_hit    = ACK && i_mmio_ack;
    assign timer_load = (state_q == ACCESS);
    assign timer_dec  = (state_q == WAIT);
    assign unused_addr = ^i_io_address;

    // An error is committed in the cycle before the ERROR state, so clear loses to it there.
    assign err_event = ((state_q == IDLE) && start && !in_window) ||
                       ((state_q == WAIT) && ACK && !i_mmio_ack && timer_expired);

    mmio_wait_timer #(
        .W (TIMER_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (timer_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (timer_dec),
        .o_expired  (timer_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            is_read_q    <= 1'b0;
            io_ready_q   <= 1'b0;
            io_rdata_q   <= '0;
            mmio_cs_q    <= 1'b0;
            mmio_read_q  <= 1'b0;
            mmio_write_q <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_be_q    <= '0;
            mmio_wdata_q <= '0;
        end else begin
            io_ready_q   <= 1'b0;
            mmio_cs_q    <= 1'b0;
            mmio_read_q  <= 1'b0;
            mmio_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_read_q    <= i_io_read_strobe;
                        mmio_addr_q  <= i_io_address[ADDR_W+1:2];
                        mmio_be_q    <= i_io_byte_enable;
                        mmio_wdata_q <= i_io_write_data;
                        if (in_window) begin
                            state_q      <= ACCESS;
                            mmio_cs_q    <= 1'b1;
                            mmio_read_q  <= i_io_read_strobe;
                            mmio_write_q <= i_io_write_strobe;
                        end else begin
                            state_q    <= ERROR;
                            io_ready_q <= 1'b1;
                            io_rdata_q <= i_io_read_strobe ? ERR_WORD : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_hit) begin
                        state_q    <= DONE;
                        io_ready_q <= 1'b1;
                        io_rdata_q <= is_read_q ? i_mmio_read_data : 32'h0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack_hit || (!ACK && timer_expired)) begin
                        state_q    <= DONE;
                        io_ready_q <= 1'b1;
                        io_rdata_q <= is_read_q ? i_mmio_read_data : 32'h0;
                    end else if (ACK && timer_expired) begin
                        state_q    <= ERROR;
                        io_ready_q <= 1'b1;
                        io_rdata_q <= is_read_q ? ERR_WORD : 32'h0;
                    end
                end
                DONE, ERROR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        if (err_event) begin
            err_flag_d  = 1'b1;
            err_count_d = i_err_clear ? 8'd1 : sat_inc(err_count_q);
        end else if (i_err_clear) begin
            err_flag_d  = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
        end
    end

    assign o_io_read_data    = io_rdata_q;
    assign o_io_ready        = io_ready_q;
    assign o_mmio_cs         = mmio_cs_q;
    assign o_mmio_read       = mmio_read_q;
    assign o_mmio_write      = mmio_write_q;
    assign o_mmio_addr       = mmio_addr_q;
    assign o_mmio_byte_en    = mmio_be_q;
    assign o_mmio_write_data = mmio_wdata_q;
    assign o_err_flag        = err_flag_q;
    assign o_err_count       = err_count_q;

endmodule

// File: tb/tb_io_mmio_bridge_wait.sv
// Randomized bench for io_mmio_bridge_wait: a fixed-latency and an ack-mode instance
// share one stimulus bus and are checked one at a time against a transaction-level model.
module tb_io_mmio_bridge_wait;

    localparam int RL = 2;
    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        cs;
        logic        rd;
        logic        wr;
        logic [20:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        logic        flag;
        logic [7:0]  cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        as = 1'b0, rs = 1'b0, ws = 1'b0, ack = 1'b0, clr = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0, sdata = '0;
    obs_t        f_o, a_o, o;
    bit          sel = 1'b0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;
    assign o = sel ? a_o : f_o;

    io_mmio_bridge_wait #(.ADDR_W(21), .ACK_MODE(0), .READ_LATENCY(RL), .TIMEOUT(TO)) dut_fix (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_io_addr_strobe(as), .i_io_read_strobe(rs), .i_io_write_strobe(ws),
        .i_io_byte_enable(be), .i_io_address(addr), .i_io_write_data(wdata),
        .o_io_read_data(f_o.rdata), .o_io_ready(f_o.ready),
        .o_mmio_cs(f_o.cs), .o_mmio_write(f_o.wr), .o_mmio_read(f_o.rd),
        .o_mmio_addr(f_o.maddr), .o_mmio_byte_en(f_o.mbe), .o_mmio_write_data(f_o.mwd),
        .i_mmio_read_data(sdata), .i_mmio_ack(ack), .i_err_clear(clr),
        .o_err_flag(f_o.flag), .o_err_count(f_o.cnt)
    );

    io_mmio_bridge_wait #(.ADDR_W(21), .ACK_MODE(1), .READ_LATENCY(RL), .TIMEOUT(TO)) dut_ack (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_io_addr_strobe(as), .i_io_read_strobe(rs), .i_io_write_strobe(ws),
        .i_io_byte_enable(be), .i_io_address(addr), .i_io_write_data(wdata),
        .o_io_read_data(a_o.rdata), .o_io_ready(a_o.ready),
        .o_mmio_cs(a_o.cs), .o_mmio_write(a_o.wr), .o_mmio_read(a_o.rd),
        .o_mmio_addr(a_o.maddr), .o_mmio_byte_en(a_o.mbe), .o_mmio_write_data(a_o.mwd),
        .i_mmio_read_data(sdata), .i_mmio_ack(ack), .i_err_clear(clr),
        .o_err_flag(a_o.flag), .o_err_count(a_o.cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ntx = 0;

    // Current transaction as seen by the model: start cycle and resulting schedule.
    bit          t_valid = 1'b0;
    int          t0 = 0;
    bit          t_rd, t_win, t_err;
    int          t_roff;
    logic [20:0] t_addr;
    logic [3:0]  t_be;
    logic [31:0] t_wd, t_rdata;

    // Model of the observable registers.
    logic [20:0] m_addr = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_wd = '0, m_rdata = '0;
    bit          m_flag = 1'b0;
    int          m_cnt = 0;
    bit          prev_clr = 1'b0;

    int seen_rdy_off = -1, seen_cs_off = -1;
    logic [31:0] seen_rdy_data = '0;
    logic [20:0] seen_cs_addr = '0;

    int off;
    bit cs_e, rdy_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            off   = cyc - t0;
            cs_e  = t_valid && t_win && (off == 1);
            rdy_e = t_valid && (off == t_roff);
            if (t_valid && off == 1) begin
                m_addr = t_addr;
                m_be   = t_be;
                m_wd   = t_wd;
            end
            if (rdy_e) m_rdata = t_rdata;
            if (rdy_e && t_err) begin
                m_flag = 1'b1;
                m_cnt  = prev_clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            end else if (prev_clr) begin
                m_flag = 1'b0;
                m_cnt  = 0;
            end
            check("ready", 32'(o.ready), 32'(rdy_e));
            check("cs", 32'(o.cs), 32'(cs_e));
            check("mmio_rd", 32'(o.rd), 32'(cs_e && t_rd));
            check("mmio_wr", 32'(o.wr), 32'(cs_e && !t_rd));
            check("mmio_addr", 32'(o.maddr), 32'(m_addr));
            check("mmio_be", 32'(o.mbe), 32'(m_be));
            check("mmio_wd", o.mwd, m_wd);
            check("rdata", o.rdata, m_rdata);
            check("err_flag", 32'(o.flag), 32'(m_flag));
            check("err_cnt", 32'(o.cnt), 32'(m_cnt));
            if (o.ready) begin
                seen_rdy_off  = off;
                seen_rdy_data = o.rdata;
            end
            if (o.cs) begin
                seen_cs_off  = off;
                seen_cs_addr = o.maddr;
            end
            prev_clr = clr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet(input bit ackv);
        {as, rs, ws} = 3'b000;
        ack = ackv;
        clr = 1'b0;
        sdata = $urandom;
    endtask

    task automatic drive_idle();
        logic [2:0] s;
        s = 3'($urandom);
        {as, rs, ws} = s;
        if (as && (rs ^ ws)) ws = rs;
        addr = $urandom; be = 4'($urandom); wdata = $urandom; sdata = $urandom;
        ack = 1'($urandom);
        clr = ($urandom_range(0, 7) == 0);
    endtask

    task automatic do_reset(input bit s);
        rst_n = 1'b0;
        #1;
        sel = s;
        #1;
        check("rst_ready", 32'(o.ready), 32'h0);
        check("rst_rdata", o.rdata, 32'h0);
        check("rst_cs", 32'(o.cs | o.rd | o.wr), 32'h0);
        check("rst_addr", 32'(o.maddr), 32'h0);
        check("rst_flag", 32'(o.flag), 32'h0);
        check("rst_cnt", 32'(o.cnt), 32'h0);
        t_valid = 1'b0; m_addr = '0; m_be = '0; m_wd = '0; m_rdata = '0;
        m_flag = 1'b0; m_cnt = 0; prev_clr = 1'b0;
        quiet(1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ackk: ack cycle offset (0 = never); rst_at: cycle offset for a mid-flight reset (0 = none).
    task automatic run_txn(input bit rd, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] w, input int ackk, input logic [31:0] dval,
                           input bit stray, input bit clr0, input int rst_at);
        bit win, err;
        int roff, samp;
        win  = (a[31:30] == 2'b11);
        err  = !win || (sel && !(ackk >= 1 && ackk <= TO + 1));
        if (!win)      roff = 1;
        else if (!sel) roff = 2 + RL;
        else if (err)  roff = 2 + TO;
        else           roff = ackk + 1;
        samp = sel ? ackk : 1 + RL;
        tick();
        as = 1'b1; rs = rd; ws = !rd; addr = a; be = b; wdata = w;
        sdata = $urandom; ack = 1'($urandom); clr = clr0;
        t0 = cyc; t_rd = rd; t_win = win; t_err = err; t_roff = roff;
        t_addr = a[22:2]; t_be = b; t_wd = w;
        t_rdata = !rd ? 32'h0 : (err ? 32'hDEAD_BEEF : dval);
        t_valid = 1'b1;
        seen_rdy_off = -1; seen_cs_off = -1;
        ntx++;
        $display("txn %0d mode=%0d %s addr=%h be=%h wd=%h ack_at=%0d: ready T%0d rdata %h",
                 ntx, sel, rd ? "rd" : "wr", a, b, w, ackk, roff, t_rdata);
        for (int k = 1; k <= roff; k++) begin
            tick();
            {as, rs, ws} = stray ? 3'($urandom) : 3'b000;
            addr = $urandom; be = 4'($urandom); wdata = $urandom; clr = 1'b0;
            sdata = (k == samp) ? dval : $urandom;
            ack = (sel && k < roff) ? (k == ackk) : 1'($urandom);
            if (k == rst_at) begin
                #2;
                do_reset(sel);
                return;
            end
        end
    endtask

    task automatic rand_txn();
        logic [31:0] a;
        int ackk;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[31:30] = 2'b11;
        else a[31:30] = 2'($urandom_range(0, 2));
        ackk = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO + 1);
        run_txn(1'($urandom), a, 4'($urandom), $urandom, ackk, $urandom,
                1'($urandom), ($urandom_range(0, 5) == 0), 0);
        repeat ($urandom_range(0, 2)) begin
            tick();
            drive_idle();
        end
    endtask

    initial begin
        #2;
        do_reset(1'b0);
        chk_en = 1'b1;

        // Fixed-latency read, slave data 0x1234_5678.
        run_txn(1'b1, 32'hC000_0010, 4'hF, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b0, 0);
        settle();
        check("fix_cs_off", 32'(seen_cs_off), 32'd1);
        check("fix_cs_addr", 32'(seen_cs_addr), 32'd4);
        check("fix_rdy_off", 32'(seen_rdy_off), 32'd4);
        check("fix_rdy_data", seen_rdy_data, 32'h1234_5678);

        // Out-of-window read.
        run_txn(1'b1, 32'h4000_0000, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0, 0);
        settle();
        check("oow_rdy_off", 32'(seen_rdy_off), 32'd1);
        check("oow_data", seen_rdy_data, 32'hDEAD_BEEF);
        check("oow_no_cs", 32'(seen_cs_off), 32'hFFFF_FFFF);

        // Saturate the error counter, then clear coinciding with an error.
        for (int i = 0; i < 256; i++)
            run_txn(1'($urandom), 32'h8000_0000 | $urandom_range(0, 1024), 4'hF, $urandom,
                    0, 32'h0, 1'b0, 1'b0, 0);
        settle();
        check("sat_cnt", 32'(o.cnt), 32'd255);
        run_txn(1'b1, 32'h0000_0040, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b1, 0);
        settle();
        check("clr_vs_err_cnt", 32'(o.cnt), 32'd1);
        check("clr_vs_err_flag", 32'(o.flag), 32'd1);

        // Reset while in WAIT, then a normal transaction.
        run_txn(1'b1, 32'hC000_0020, 4'hF, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 3);
        repeat (4) begin
            tick();
            quiet(1'b0);
        end
        settle();
        check("rst_no_ready", 32'(seen_rdy_off), 32'hFFFF_FFFF);
        run_txn(1'b0, 32'hC000_0100, 4'hC, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, 1'b0, 0);
        settle();
        check("post_rst_rdy_off", 32'(seen_rdy_off), 32'd4);

        for (int i = 0; i < 150; i++) rand_txn();

        do_reset(1'b1);

        // Ack-mode write acknowledged at T5.
        run_txn(1'b0, 32'hC000_0200, 4'b0011, 32'hA5A5_A5A5, 5, 32'h0, 1'b0, 1'b0, 0);
        settle();
        check("ackw_rdy_off", 32'(seen_rdy_off), 32'd6);
        check("ackw_data", seen_rdy_data, 32'h0);

        // Ack in the ACCESS cycle.
        run_txn(1'b1, 32'hC000_0300, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 0);
        settle();
        check("ack1_rdy_off", 32'(seen_rdy_off), 32'd2);
        check("ack1_data", seen_rdy_data, 32'h0BAD_F00D);

        // Timeout with no ack, then a late ack at T12.
        run_txn(1'b1, 32'hC000_0400, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1'b0, 0);
        settle();
        check("to_rdy_off", 32'(seen_rdy_off), 32'd10);
        check("to_data", seen_rdy_data, 32'hDEAD_BEEF);
        check("to_flag", 32'(o.flag), 32'd1);
        check("to_cnt", 32'(o.cnt), 32'd1);
        seen_rdy_off = -1;
        tick(); quiet(1'b0);
        tick(); quiet(1'b1);
        tick(); quiet(1'b0);
        settle();
        check("late_ack_no_ready", 32'(seen_rdy_off), 32'hFFFF_FFFF);
        check("late_ack_cnt", 32'(o.cnt), 32'd1);

        for (int i = 0; i < 150; i++) rand_txn();

        tick();
        quiet(1'b0);
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
